mem_arbiter: RTL and testbench

Arbitrates the single-ported, fixed-latency main memory between the I-cache miss FSM and the D-cache miss/write path. It sequences 8-word block fills and single-word write-through stores onto the memory port. It returns fill data, word index and completion pulses to each requester. It drives the i_fsm_busy/d_fsm_busy stall signals consumed by the hazard unit. It sits inside the memory subsystem, between both caches and the main memory model.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_blk_counter.sv | 20 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and default block geometry for the memory arbiter
package mem_arbiter_pkg;
   typedef enum logic [2:0] {DRAIN, IDLE, I_FILL, D_FILL, D_WRITE} state_t;
   localparam int WORDS_DEF   = 8;
   localparam int MEM_LAT_DEF = 4;
   // counters need one extra bit so "all WORDS issued" is representable without wrapping
   function automatic int cnt_w(input int words);
      return $clog2(words) + 1;
   endfunction
endpackage

// File: rtl/mem_arbiter_blk_counter.sv
// blk_counter: clearable up-counter with a terminal-value flag
module blk_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] lim,
   output logic [W-1:0] cnt,
   output logic         last
);
   // clear wins over enable so a transaction ending on a count edge leaves zero behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
   assign last = cnt == lim;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbitration of I/D cache misses onto one fixed-latency memory port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WORDS   = WORDS_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_req,
   input  logic [ADDR_W-1:0]        i_addr,
   output logic                     i_fill_vld,
   output logic [DATA_W-1:0]        i_fill_data,
   output logic [$clog2(WORDS)-1:0] i_fill_word,
   output logic                     i_done,
   output logic                     i_fsm_busy,
   input  logic                     d_req,
   input  logic                     d_wr,
   input  logic [ADDR_W-1:0]        d_addr,
   input  logic [DATA_W-1:0]        d_wdata,
   output logic                     d_fill_vld,
   output logic [DATA_W-1:0]        d_fill_data,
   output logic [$clog2(WORDS)-1:0] d_fill_word,
   output logic                     d_done,
   output logic                     d_fsm_busy,
   output logic                     mem_en,
   output logic                     mem_wr,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_rvld
);
   localparam int WB = $clog2(WORDS);
   localparam int CW = cnt_w(WORDS);
   localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * 2 - 1);

   state_t            state, next;
   logic              last_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CW-1:0]     issue_cnt, recv_cnt;
   logic              issue_last, recv_last;
   logic              fill, issue_act, issue_en, recv_en, done_fill, cnt_clr, grant_d, grant_i;

   assign fill      = state == I_FILL || state == D_FILL;
   assign issue_act = ~issue_cnt[CW-1];
   assign issue_en  = state == DRAIN || (fill && issue_act);
   assign recv_en   = fill && mem_rvld && ~recv_cnt[CW-1];
   assign done_fill = recv_en && recv_last;
   assign cnt_clr   = next == IDLE;
   assign grant_d   = state == IDLE && d_req && (!i_req || !last_d);
   assign grant_i   = state == IDLE && i_req && !grant_d;

   // the issue counter doubles as the post-reset drain timer
   blk_counter #(.W(CW)) u_issue (
      .clk(clk), .rst_n(rst_n), .en(issue_en), .clr(cnt_clr),
      .lim(state == DRAIN ? CW'(MEM_LAT - 1) : CW'(WORDS - 1)),
      .cnt(issue_cnt), .last(issue_last)
   );

   blk_counter #(.W(CW)) u_recv (
      .clk(clk), .rst_n(rst_n), .en(recv_en), .clr(cnt_clr),
      .lim(CW'(WORDS - 1)), .cnt(recv_cnt), .last(recv_last)
   );

   // state register plus grant-time capture of address, data and round-robin history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= DRAIN;
         last_d  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= next;
         if (grant_d || grant_i) begin
            last_d <= grant_d;
            addr_q <= grant_i ? i_addr & ~BLK_MASK : d_wr ? d_addr & ~ADDR_W'(1) : d_addr & ~BLK_MASK;
         end
         if (grant_d && d_wr) wdata_q <= d_wdata;
      end
   end

   // next-state selection and all per-state outputs; anything not active in a state stays 0
   always_comb begin
      next = state;
      case (state)
         DRAIN:          next = issue_last ? IDLE : DRAIN;
         IDLE:           next = grant_d ? (d_wr ? D_WRITE : D_FILL) : grant_i ? I_FILL : IDLE;
         I_FILL, D_FILL: next = done_fill ? IDLE : state;
         default:        next = IDLE;
      endcase
      mem_en      = (fill && issue_act) || state == D_WRITE;
      mem_wr      = state == D_WRITE;
      mem_addr    = !mem_en ? '0 : mem_wr ? addr_q : addr_q + ADDR_W'({issue_cnt, 1'b0});
      mem_wdata   = mem_wr ? wdata_q : '0;
      i_fill_vld  = recv_en && state == I_FILL;
      i_fill_data = i_fill_vld ? mem_rdata : '0;
      i_fill_word = i_fill_vld ? recv_cnt[WB-1:0] : '0;
      i_done      = i_fill_vld && recv_last;
      d_fill_vld  = recv_en && state == D_FILL;
      d_fill_data = d_fill_vld ? mem_rdata : '0;
      d_fill_word = d_fill_vld ? recv_cnt[WB-1:0] : '0;
      d_done      = (d_fill_vld && recv_last) || state == D_WRITE;
   end

   assign i_fsm_busy = rst_n && i_req && !i_done;
   assign d_fsm_busy = rst_n && d_req && !d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
   localparam int AW = 16, DW = 16, WORDS = 8, LAT = 4;

   logic          clk = 0, rst_n = 0;
   logic          i_req = 0, d_req = 0, d_wr = 0, inj = 0;
   logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
   logic [DW-1:0] d_wdata = '0, mem_wdata, mem_rdata, i_fill_data, d_fill_data;
   logic [2:0]    i_fill_word, d_fill_word;
   logic          i_fill_vld, i_done, i_fsm_busy, d_fill_vld, d_done, d_fsm_busy;
   logic          mem_en, mem_wr, mem_rvld;
   logic [LAT-1:0] pv = '0;
   logic [DW-1:0]  pd [LAT];
   logic [77:0]    all_outs;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_fill_vld(i_fill_vld), .i_fill_data(i_fill_data),
      .i_fill_word(i_fill_word), .i_done(i_done), .i_fsm_busy(i_fsm_busy),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_fill_vld(d_fill_vld), .d_fill_data(d_fill_data), .d_fill_word(d_fill_word),
      .d_done(d_done), .d_fsm_busy(d_fsm_busy),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvld(mem_rvld)
   );

   always #5 clk = ~clk;

   assign all_outs = {mem_en, mem_wr, mem_addr, mem_wdata, i_fill_vld, i_fill_data, i_fill_word,
                      i_done, i_fsm_busy, d_fill_vld, d_fill_data, d_fill_word, d_done, d_fsm_busy};

   // memory model: read data is the address xor a pattern, returned LAT cycles after issue; not reset
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
      pd[0] <= mem_addr ^ 16'h5A5A;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign mem_rvld  = pv[LAT-1] | inj;
   assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int cyc; logic [63:0] v;} ev_t;
   ev_t sbq [5][$];
   int total = 0, passed = 0;

   task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic sb(input int k, input string name, input logic [63:0] v);
      ev_t e;
      total++;
      if (sbq[k].size() == 0) $display("FAIL %s: unexpected event %h at cycle %0d", name, v, cyc);
      else begin
         e = sbq[k].pop_front();
         if (e.cyc == cyc && e.v === v) passed++;
         else $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", name, v, cyc, e.v, e.cyc);
      end
   endtask

   task automatic push(input int k, input int c, input logic [63:0] v);
      ev_t e;
      e.cyc = c;
      e.v = v;
      sbq[k].push_back(e);
   endtask

   task automatic exp_read(input logic [15:0] a, input int c);
      push(0, c, {31'd0, 1'b0, a, 16'd0});
   endtask

   // fill whose first issue is in cycle s; d selects the D side
   task automatic exp_fill(input bit d, input logic [15:0] base, input int s);
      for (int k = 0; k < WORDS; k++) begin
         exp_read(base + 16'(2 * k), s + k);
         push(d ? 3 : 1, s + LAT + k, {45'd0, 3'(k), (base + 16'(2 * k)) ^ 16'h5A5A});
      end
      push(d ? 4 : 2, s + LAT + WORDS - 1, 64'd0);
   endtask

   task automatic exp_write(input logic [15:0] a, input logic [15:0] dat, input int s);
      push(0, s, {31'd0, 1'b1, a, dat});
      push(4, s, 64'd0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor: every presented output event is matched against the scoreboard
   always @(negedge clk) begin
      if (mem_en) sb(0, "mem", {31'd0, mem_wr, mem_addr, mem_wdata});
      if (i_fill_vld) sb(1, "i_fill", {45'd0, i_fill_word, i_fill_data});
      if (i_done) sb(2, "i_done", 64'd0);
      if (d_fill_vld) sb(3, "d_fill", {45'd0, d_fill_word, d_fill_data});
      if (d_done) sb(4, "d_done", 64'd0);
   end

   int c0, r;
   initial begin
      i_req = 1;
      i_addr = 16'h1236;
      #2;
      chk("reset_outs", all_outs, 0);
      i_req = 0;
      step(2);
      rst_n = 1;
      step(4);
      // lone I fill
      c0 = cyc;
      i_req = 1;
      exp_fill(0, 16'h1230, c0 + 1);
      #1 chk("i_busy_c0", i_fsm_busy, 1);
      step(11);
      chk("i_busy_c11", i_fsm_busy, 1);
      step(1);
      chk("i_busy_done", {i_done, i_fsm_busy}, 2'b10);
      i_req = 0;
      step(1);
      // both requesting after an I grant: D first, then I
      c0 = cyc;
      i_req = 1; i_addr = 16'h2000;
      d_req = 1; d_wr = 0; d_addr = 16'h3010;
      exp_fill(1, 16'h3010, c0 + 1);
      exp_fill(0, 16'h2000, c0 + 14);
      step(12);
      d_req = 0;
      #1 chk("i_busy_waiting", i_fsm_busy, 1);
      step(13);
      i_req = 0;
      step(1);
      // single-word writes, aligned and odd address
      c0 = cyc;
      d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
      exp_write(16'h0040, 16'hBEEF, c0 + 1);
      #1 chk("d_busy_wr_wait", d_fsm_busy, 1);
      step(1);
      chk("d_busy_wr_done", d_fsm_busy, 0);
      d_req = 0;
      step(1);
      c0 = cyc;
      d_req = 1; d_addr = 16'h0077; d_wdata = 16'h1234;
      exp_write(16'h0076, 16'h1234, c0 + 1);
      step(1);
      d_req = 0;
      step(1);
      // both requesting after a D grant: I first, then D
      c0 = cyc;
      i_req = 1; i_addr = 16'h4008;
      d_req = 1; d_wr = 0; d_addr = 16'h500F;
      exp_fill(0, 16'h4000, c0 + 1);
      exp_fill(1, 16'h5000, c0 + 14);
      step(12);
      i_req = 0;
      #1 chk("d_busy_waiting", d_fsm_busy, 1);
      step(13);
      d_req = 0;
      step(1);
      // D request arriving mid I fill waits for I done
      c0 = cyc;
      i_req = 1; i_addr = 16'h7010;
      exp_fill(0, 16'h7010, c0 + 1);
      step(3);
      d_req = 1; d_addr = 16'h8020;
      exp_fill(1, 16'h8020, c0 + 14);
      #1 chk("d_busy_c3", d_fsm_busy, 1);
      step(9);
      i_req = 0;
      step(1);
      chk("d_busy_c13", d_fsm_busy, 1);
      step(12);
      d_req = 0;
      step(1);
      // stray response while idle
      inj = 1;
      #1 chk("idle_rvld", {i_fill_vld, d_fill_vld, i_fill_data, d_fill_data}, 0);
      step(1);
      inj = 0;
      // request dropped early still completes
      c0 = cyc;
      i_req = 1; i_addr = 16'h9ABC;
      exp_fill(0, 16'h9AB0, c0 + 1);
      step(2);
      i_req = 0;
      #1 chk("i_busy_dropped", i_fsm_busy, 0);
      step(11);
      // reset mid-fill, stale responses discarded, drain delays the next grant
      c0 = cyc;
      i_req = 1; i_addr = 16'hA000;
      for (int k = 0; k < 3; k++) exp_read(16'hA000 + 16'(2 * k), c0 + 1 + k);
      step(4);
      rst_n = 0;
      #1 chk("reset_async", all_outs, 0);
      i_addr = 16'hB004;
      step(1);
      chk("stale_in_reset", i_fill_vld, 0);
      step(1);
      rst_n = 1;
      r = cyc;
      exp_fill(0, 16'hB000, r + 5);
      step(1);
      inj = 1;
      #1 chk("stale_in_drain", i_fill_vld, 0);
      step(1);
      inj = 0;
      step(2);
      chk("drain_end", {mem_en, i_fsm_busy}, 2'b01);
      step(12);
      i_req = 0;
      step(3);
      for (int k = 0; k < 5; k++) chk("sb_empty", 80'(sbq[k].size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
